// File: rtl/sprite_rom_arbiter_if.sv
// sprite_rom_arbiter_if: client request, ROM and response bundle for the sprite ROM arbiter
// slave modport (arbiter side):
//   in  flush, req, req_addr, rom_data
//   out gnt, rom_en, rom_addr, rsp_valid, rsp_data
// master modport: the same signals with the directions reversed (clients, ROM, composer).
interface sprite_rom_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 4
);
  logic                      flush;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        gnt;
  logic                      rom_en;
  logic [ADDR_W-1:0]         rom_addr;
  logic [DATA_W-1:0]         rom_data;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_data;
  modport slave (
    input  flush, req, req_addr, rom_data,
    output gnt, rom_en, rom_addr, rsp_valid, rsp_data
  );
  modport master (
    output flush, req, req_addr, rom_data,
    input  gnt, rom_en, rom_addr, rsp_valid, rsp_data
  );
endinterface

// File: rtl/sprite_rom_arbiter.sv
// sprite_rom_arbiter: round-robin sharing of one fixed-latency sprite ROM among NUM_REQ render clients
// Ports: clk, rst_n (async, active-low), bus (sprite_rom_arbiter_if.slave):
//   flush/req/req_addr from clients, gnt back to clients, rom_en/rom_addr/rom_data to the ROM,
//   rsp_valid/rsp_data (registered, one-hot owner) to the pixel composer.
// Option: define SPRITE_ARB_FIXED_PRI0_EN to give client 0 absolute priority,
//   with clients 1..NUM_REQ-1 round-robin among themselves.
module sprite_rom_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 4,
  parameter int ROM_LAT = 2
) (
  input logic                clk,
  input logic                rst_n,
  sprite_rom_arbiter_if.slave bus
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int OW = ROM_LAT * PW;
`ifdef SPRITE_ARB_FIXED_PRI0_EN
  localparam logic [PW-1:0] PTR_RST = PW'(1);
`else
  localparam logic [PW-1:0] PTR_RST = '0;
`endif
  logic [PW-1:0]               rr_ptr_q, rr_ptr_d, sel;
  logic                        found, grant;
  int                          idx;
  logic [ROM_LAT-1:0]          vld_q, vld_d;
  logic [ROM_LAT-1:0][PW-1:0]  own_q, own_d;
  logic [NUM_REQ-1:0]          rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]           rsp_data_q, rsp_data_d;
  logic                        deliver;
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = 0;
`ifdef SPRITE_ARB_FIXED_PRI0_EN
    found = bus.req[0];
    for (int j = 0; j < NUM_REQ-1; j++) begin
      idx = 1 + (int'(rr_ptr_q) - 1 + j) % (NUM_REQ-1);
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        sel   = PW'(idx);
      end
    end
`else
    for (int j = 0; j < NUM_REQ; j++) begin
      idx = (int'(rr_ptr_q) + j) % NUM_REQ;
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        sel   = PW'(idx);
      end
    end
`endif
    grant = found && !bus.flush;
  end
  assign bus.gnt      = grant ? NUM_REQ'(1) << sel : '0;
  assign bus.rom_en   = grant;
  assign bus.rom_addr = grant ? bus.req_addr[sel*ADDR_W +: ADDR_W] : '0;
  always_comb begin
`ifdef SPRITE_ARB_FIXED_PRI0_EN
    rr_ptr_d = bus.flush ? PTR_RST
             : (grant && sel != '0) ? ((sel == PW'(NUM_REQ-1)) ? PW'(1) : sel + PW'(1))
             : rr_ptr_q;
`else
    rr_ptr_d = bus.flush ? PTR_RST
             : grant ? ((sel == PW'(NUM_REQ-1)) ? '0 : sel + PW'(1))
             : rr_ptr_q;
`endif
    // owner tags ride alongside the ROM pipeline; the size casts drop the oldest stage
    vld_d       = bus.flush ? '0 : ROM_LAT'({vld_q, grant});
    own_d       = OW'({own_q, sel});
    deliver     = vld_q[ROM_LAT-1] && !bus.flush;
    rsp_valid_d = deliver ? NUM_REQ'(1) << own_q[ROM_LAT-1] : '0;
    rsp_data_d  = deliver ? bus.rom_data : rsp_data_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q    <= PTR_RST;
      vld_q       <= '0;
      own_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      vld_q       <= vld_d;
      own_q       <= own_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
endmodule
